mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Moore control FSM that sequences a multi-cycle MIPS datapath: shared instruction/data memory, single ALU, IR/MDR/A/B/ALUOut latches.
- Decodes the opcode, steps each instruction through fetch/decode/execute/memory/writeback, and drives all datapath mux selects and write enables.
- Adds a req/ready handshake to the shared memory with a timeout watchdog, so slow memories can stall the core.

Parameters:
- TIMEOUT, 15, max cycles waiting for mem_ready in one memory state; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  write strobe, valid with mem_req
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR
- pc_en  out  1  PC load enable = pc_write | (branch & zero)
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 use funct
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- bus_error  out  1  one-cycle pulse on memory timeout
- state  out  4  current state (debug)

Behaviour:
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- State encoding: RESET 0, FETCH 1, DECODE 2, MEMADR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECUTE 7, ALUWB 8, BRANCH 9, ADDIEXEC 10, ADDIWB 11, JUMP 12.
- Reset (rst low): state = RESET and the wait counter clears, asynchronously. In RESET, all outputs are 0. RESET advances to FETCH on the first clock edge after rst deasserts.
- All outputs decode from state only. The only exceptions are the mem_ready-qualified enables, pc_en, and the two pulses. Any signal not listed for a state is 0.
- FETCH:
  - Drives mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write assert only in the cycle mem_ready=1; the FSM then moves to DECODE. Otherwise it holds.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state: lw/sw → MEMADR, R → EXECUTE, beq → BRANCH, addi → ADDIEXEC, j → JUMP.
  - Any other opcode → FETCH with illegal_op=1 that cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, iord=1. Holds until mem_ready, then → MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- MEMWRITE: mem_req=1, mem_write=1, iord=1. Holds until mem_ready, then → FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. pc_en=zero. Next state FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- JUMP: pc_src=10, pc_write=1. Next state FETCH.
- Latency with mem_ready tied high: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.
- Each wait state adds exactly one cycle per low mem_ready cycle.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to FETCH, MEMREAD or MEMWRITE, and increments each cycle that mem_ready=0 in those states.
  - When it reaches TIMEOUT with mem_ready still 0: pulse bus_error, skip all enables, go to FETCH.
  - From MEMREAD/MEMWRITE this abandons the instruction. From FETCH it retries the same PC.
  - Counter is 8 bits wide and saturates.
- rst asserted mid-instruction (including during a wait state): immediate return to RESET. No write enable may assert after rst falls.

Test Plan:
- Release rst with opcode=000000, mem_ready=1 → state 0,1,2,7,8,1. reg_write=1 and reg_dst=1 only in state 8. Four ir_write/pc_en pulses over 16 cycles.
- lw (100011) with mem_ready low 3 cycles in MEMREAD → sequence 1,2,3,4,4,4,4,5,1. mem_req high in each state-4 cycle. mem_to_reg=1 and reg_write=1 in state 5.
- beq (000100): zero=1 → pc_en=1 with pc_src=01 in BRANCH. Repeat with zero=0 → pc_en=0. Both cases return to FETCH after 3 cycles.
- Opcode 111111 → illegal_op pulses one cycle in DECODE, next state FETCH, no reg_write or mem_write asserted.
- TIMEOUT=15, mem_ready held 0 during sw MEMWRITE → bus_error pulses once on the 15th wait cycle. mem_write never coincides with mem_ready; next state FETCH.
- rst driven low during MEMWRITE wait → state=0 and all outputs 0 within the same cycle (asynchronous). Resume is clean from FETCH.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for a multi-cycle MIPS datapath with a shared memory port.
// Memory states handshake on mem_ready and are bounded by a TIMEOUT-cycle watchdog.
module mips_multicycle_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       illegal_op,
   output logic       bus_error,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      StReset    = 4'd0,
      StFetch    = 4'd1,
      StDecode   = 4'd2,
      StMemAdr   = 4'd3,
      StMemRead  = 4'd4,
      StMemWb    = 4'd5,
      StMemWrite = 4'd6,
      StExecute  = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9,
      StAddiExec = 4'd10,
      StAddiWb   = 4'd11,
      StJump     = 4'd12
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpJ     = 6'b000010;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       mem_wait;
   logic       timeout;
   logic       pc_write;
   logic       branch;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StReset;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_wait = ((state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite))
                     && !mem_ready;
   // Fires on the TIMEOUT-th consecutive stalled cycle of one memory state.
   assign timeout  = mem_wait && (TIMEOUT != 0) && ({24'd0, cnt_q} == TIMEOUT - 32'd1);

   // Any exit from a wait (ready, timeout or a non-memory state) leaves the counter cleared.
   always_comb begin
      cnt_d = '0;
      if (mem_wait && !timeout) begin
         cnt_d = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
      end
   end

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
      bus_error  = 1'b0;

      case (state_q)
         StReset: state_d = StFetch;
         StFetch: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end else if (timeout) begin
               bus_error = 1'b1;
               state_d   = StFetch;
            end
         end
         StDecode: begin
            alu_src_b = 2'b11;
            case (opcode)
               OpLw, OpSw: state_d = StMemAdr;
               OpRtype:    state_d = StExecute;
               OpBeq:      state_d = StBranch;
               OpAddi:     state_d = StAddiExec;
               OpJ:        state_d = StJump;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = StFetch;
               end
            endcase
         end
         StMemAdr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (opcode == OpSw) ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               state_d = StMemWb;
            end else if (timeout) begin
               bus_error = 1'b1;
               state_d   = StFetch;
            end
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = StFetch;
         end
         StMemWrite: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) begin
               state_d = StFetch;
            end else if (timeout) begin
               bus_error = 1'b1;
               state_d   = StFetch;
            end
         end
         StExecute: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = StAluWb;
         end
         StAluWb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = StFetch;
         end
         StBranch: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            branch    = 1'b1;
            state_d   = StFetch;
         end
         StAddiExec: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = StAddiWb;
         end
         StAddiWb: begin
            reg_write = 1'b1;
            state_d   = StFetch;
         end
         StJump: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
            state_d  = StFetch;
         end
         default: state_d = StReset;
      endcase
   end

   assign pc_en = pc_write | (branch & zero);
   assign state = state_q;

endmodule
